// File: rtl/riscv_cpu_pipelined.sv
// Five-stage in-order RV64I-subset core (IF/ID/EX/MEM/WB) with private instruction
// memory, register file and data memory; raises end_program on the halt sentinel.

module riscv_imem #(
    parameter int DEPTH = 256
) (
    input  logic [63:0] pc_i,
    output logic [31:0] instr_o
);
    localparam int IDX_W = $clog2(DEPTH);

    // Loaded from outside before reset deassertion; unloaded entries fetch as NOP.
    logic [31:0] memory [0:DEPTH-1] = '{default: 32'h0000_0013};

    always_comb begin
        instr_o = 32'h0000_0013;
        if ((pc_i >> 2) < 64'(DEPTH)) instr_o = memory[pc_i[2 +: IDX_W]];
    end
endmodule

module riscv_regfile (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    output logic [63:0] rs1_data_o,
    output logic [63:0] rs2_data_o,
    input  logic        we_i,
    input  logic [4:0]  rd_i,
    input  logic [63:0] wdata_i
);
    logic [63:0] registers [0:31];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) registers[i] <= '0;
        end else if (we_i && rd_i != 5'd0) begin
            registers[rd_i] <= wdata_i;
        end
    end

    // Same-cycle WB value is visible to ID reads.
    assign rs1_data_o = (rs1_i == 5'd0) ? 64'd0 :
                        (we_i && rd_i == rs1_i) ? wdata_i : registers[rs1_i];
    assign rs2_data_o = (rs2_i == 5'd0) ? 64'd0 :
                        (we_i && rd_i == rs2_i) ? wdata_i : registers[rs2_i];
endmodule

module riscv_dmem #(
    parameter int DEPTH = 256
) (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [63:0] addr_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] rdata_o
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [63:0] memory [0:DEPTH-1] = '{default: 64'd0};
    logic        in_range;

    assign in_range = (addr_i >> 3) < 64'(DEPTH);

    always_ff @(posedge clk_i) begin
        if (we_i && in_range) memory[addr_i[3 +: IDX_W]] <= wdata_i;
    end

    assign rdata_o = in_range ? memory[addr_i[3 +: IDX_W]] : 64'd0;
endmodule

module riscv_cpu_pipelined #(
    parameter int          IMEM_DEPTH = 256,
    parameter int          DMEM_DEPTH = 256,
    parameter logic [63:0] RESET_PC   = 64'd0
) (
    input  logic clk,
    input  logic reset,
    output logic end_program
);
    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [31:0] HALT      = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_op_e;

    function automatic logic [63:0] alu(input alu_op_e op, input logic [63:0] a,
                                        input logic [63:0] b);
        case (op)
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            default: return a + b;
        endcase
    endfunction

    // ---------------- IF ----------------
    logic [63:0] pc_q, pc_d;
    logic [31:0] fetch_instr;

    riscv_imem #(.DEPTH(IMEM_DEPTH)) imem (.pc_i(pc_q), .instr_o(fetch_instr));

    logic        ifid_vld_q, ifid_vld_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [63:0] ifid_pc_q, ifid_pc_d;

    // ---------------- ID ----------------
    logic [6:0]  id_opcode, id_f7;
    logic [4:0]  id_rd, id_rs1, id_rs2;
    logic [2:0]  id_f3;
    logic        id_regwrite, id_memread, id_memwrite, id_branch, id_alusrc;
    logic        id_use_rs1, id_use_rs2;
    alu_op_e     id_aluop;
    logic [63:0] id_imm, id_rs1_data, id_rs2_data;

    assign id_opcode = ifid_instr_q[6:0];
    assign id_rd     = ifid_instr_q[11:7];
    assign id_f3     = ifid_instr_q[14:12];
    assign id_rs1    = ifid_instr_q[19:15];
    assign id_rs2    = ifid_instr_q[24:20];
    assign id_f7     = ifid_instr_q[31:25];

    always_comb begin
        id_regwrite = 1'b0;
        id_memread  = 1'b0;
        id_memwrite = 1'b0;
        id_branch   = 1'b0;
        id_alusrc   = 1'b0;
        id_use_rs1  = 1'b0;
        id_use_rs2  = 1'b0;
        id_aluop    = ALU_ADD;
        id_imm      = {{52{ifid_instr_q[31]}}, ifid_instr_q[31:20]};
        case (id_opcode)
            OP_R: begin
                id_use_rs1 = 1'b1;
                id_use_rs2 = 1'b1;
                if (id_f3 == 3'b000 && id_f7 == 7'b0000000) begin
                    id_regwrite = 1'b1;
                    id_aluop    = ALU_ADD;
                end else if (id_f3 == 3'b000 && id_f7 == 7'b0100000) begin
                    id_regwrite = 1'b1;
                    id_aluop    = ALU_SUB;
                end else if (id_f3 == 3'b111 && id_f7 == 7'b0000000) begin
                    id_regwrite = 1'b1;
                    id_aluop    = ALU_AND;
                end else if (id_f3 == 3'b110 && id_f7 == 7'b0000000) begin
                    id_regwrite = 1'b1;
                    id_aluop    = ALU_OR;
                end
            end
            OP_IMM: begin
                if (id_f3 == 3'b000) begin
                    id_regwrite = 1'b1;
                    id_alusrc   = 1'b1;
                    id_use_rs1  = 1'b1;
                end
            end
            OP_LOAD: begin
                if (id_f3 == 3'b011) begin
                    id_regwrite = 1'b1;
                    id_memread  = 1'b1;
                    id_alusrc   = 1'b1;
                    id_use_rs1  = 1'b1;
                end
            end
            OP_STORE: begin
                id_imm = {{52{ifid_instr_q[31]}}, ifid_instr_q[31:25], ifid_instr_q[11:7]};
                if (id_f3 == 3'b011) begin
                    id_memwrite = 1'b1;
                    id_alusrc   = 1'b1;
                    id_use_rs1  = 1'b1;
                    id_use_rs2  = 1'b1;
                end
            end
            OP_BRANCH: begin
                id_imm = {{51{ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[7],
                          ifid_instr_q[30:25], ifid_instr_q[11:8], 1'b0};
                if (id_f3 == 3'b000) begin
                    id_branch  = 1'b1;
                    id_use_rs1 = 1'b1;
                    id_use_rs2 = 1'b1;
                end
            end
            default: ;
        endcase
    end

    logic        memwb_regwrite_q;
    logic [4:0]  memwb_rd_q;
    logic [63:0] memwb_wdata_q;

    riscv_regfile reg_file (
        .clk_i     (clk),
        .rst_i     (reset),
        .rs1_i     (id_rs1),
        .rs2_i     (id_rs2),
        .rs1_data_o(id_rs1_data),
        .rs2_data_o(id_rs2_data),
        .we_i      (memwb_regwrite_q),
        .rd_i      (memwb_rd_q),
        .wdata_i   (memwb_wdata_q)
    );

    logic        idex_regwrite_q, idex_memread_q, idex_memwrite_q, idex_branch_q;
    logic        idex_alusrc_q;
    alu_op_e     idex_aluop_q;
    logic [4:0]  idex_rs1_q, idex_rs2_q, idex_rd_q;
    logic [63:0] idex_pc_q, idex_rs1_data_q, idex_rs2_data_q, idex_imm_q;

    logic load_use, halt_detect, halt_q, br_taken, idex_ctrl_en;

    assign load_use = ifid_vld_q && idex_memread_q && idex_rd_q != 5'd0 &&
                      ((id_use_rs1 && id_rs1 == idex_rd_q) ||
                       (id_use_rs2 && id_rs2 == idex_rd_q));
    assign halt_detect  = ifid_vld_q && ifid_instr_q == HALT && !br_taken;
    assign idex_ctrl_en = ifid_vld_q && !br_taken && !load_use;
    assign end_program  = halt_q;

    // ---------------- EX ----------------
    logic        exmem_regwrite_q, exmem_memread_q, exmem_memwrite_q;
    logic [4:0]  exmem_rd_q;
    logic [63:0] exmem_alu_q, exmem_sdata_q;
    logic [63:0] ex_op_a, ex_op_b, ex_alu_b, ex_alu_res, br_target;

    // EX/MEM takes priority over MEM/WB; x0 and non-writing producers never forward.
    always_comb begin
        ex_op_a = idex_rs1_data_q;
        if (exmem_regwrite_q && exmem_rd_q != 5'd0 && exmem_rd_q == idex_rs1_q)
            ex_op_a = exmem_alu_q;
        else if (memwb_regwrite_q && memwb_rd_q != 5'd0 && memwb_rd_q == idex_rs1_q)
            ex_op_a = memwb_wdata_q;
        ex_op_b = idex_rs2_data_q;
        if (exmem_regwrite_q && exmem_rd_q != 5'd0 && exmem_rd_q == idex_rs2_q)
            ex_op_b = exmem_alu_q;
        else if (memwb_regwrite_q && memwb_rd_q != 5'd0 && memwb_rd_q == idex_rs2_q)
            ex_op_b = memwb_wdata_q;
    end

    assign ex_alu_b   = idex_alusrc_q ? idex_imm_q : ex_op_b;
    assign ex_alu_res = alu(idex_aluop_q, ex_op_a, ex_alu_b);
    assign br_taken   = idex_branch_q && (ex_op_a == ex_op_b);
    assign br_target  = idex_pc_q + idex_imm_q;

    // ---------------- MEM ----------------
    logic [63:0] mem_rdata;

    riscv_dmem #(.DEPTH(DMEM_DEPTH)) dmem (
        .clk_i  (clk),
        .we_i   (exmem_memwrite_q && !reset),
        .addr_i (exmem_alu_q),
        .wdata_i(exmem_sdata_q),
        .rdata_o(mem_rdata)
    );

    // ---------------- next-state: PC and IF/ID ----------------
    always_comb begin
        pc_d         = pc_q + 64'd4;
        ifid_vld_d   = 1'b1;
        ifid_instr_d = fetch_instr;
        ifid_pc_d    = pc_q;
        if (br_taken) begin
            pc_d       = br_target;
            ifid_vld_d = 1'b0;
        end else if (load_use) begin
            pc_d         = pc_q;
            ifid_vld_d   = ifid_vld_q;
            ifid_instr_d = ifid_instr_q;
            ifid_pc_d    = ifid_pc_q;
        end else if (halt_detect || halt_q) begin
            pc_d       = pc_q;
            ifid_vld_d = 1'b0;
        end
    end

    // Control state: cleared by reset so every stage restarts as a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q             <= RESET_PC;
            ifid_vld_q       <= 1'b0;
            idex_regwrite_q  <= 1'b0;
            idex_memread_q   <= 1'b0;
            idex_memwrite_q  <= 1'b0;
            idex_branch_q    <= 1'b0;
            exmem_regwrite_q <= 1'b0;
            exmem_memread_q  <= 1'b0;
            exmem_memwrite_q <= 1'b0;
            memwb_regwrite_q <= 1'b0;
            halt_q           <= 1'b0;
        end else begin
            pc_q             <= pc_d;
            ifid_vld_q       <= ifid_vld_d;
            idex_regwrite_q  <= idex_ctrl_en && id_regwrite;
            idex_memread_q   <= idex_ctrl_en && id_memread;
            idex_memwrite_q  <= idex_ctrl_en && id_memwrite;
            idex_branch_q    <= idex_ctrl_en && id_branch;
            exmem_regwrite_q <= idex_regwrite_q;
            exmem_memread_q  <= idex_memread_q;
            exmem_memwrite_q <= idex_memwrite_q;
            memwb_regwrite_q <= exmem_regwrite_q;
            halt_q           <= halt_q || halt_detect;
        end
    end

    // Datapath registers carry no reset; bubbles are defined by the control bits.
    always_ff @(posedge clk) begin
        ifid_instr_q    <= ifid_instr_d;
        ifid_pc_q       <= ifid_pc_d;
        idex_alusrc_q   <= id_alusrc;
        idex_aluop_q    <= id_aluop;
        idex_rs1_q      <= id_rs1;
        idex_rs2_q      <= id_rs2;
        idex_rd_q       <= id_rd;
        idex_pc_q       <= ifid_pc_q;
        idex_rs1_data_q <= id_rs1_data;
        idex_rs2_data_q <= id_rs2_data;
        idex_imm_q      <= id_imm;
        exmem_rd_q      <= idex_rd_q;
        exmem_alu_q     <= ex_alu_res;
        exmem_sdata_q   <= ex_op_b;
        memwb_rd_q      <= exmem_rd_q;
        memwb_wdata_q   <= exmem_memread_q ? mem_rdata : exmem_alu_q;
    end
endmodule

// File: tb/tb_riscv_cpu_pipelined.sv
// Program-level bench: loads small programs, runs to end_program, and checks
// registers, data memory and run length from a queue of expected results.

module tb_riscv_cpu_pipelined;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic end_program;

    riscv_cpu_pipelined dut (.clk(clk), .reset(reset), .end_program(end_program));

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 register, 1 data memory word, 2 run length in cycles
        int          idx;
        logic [63:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] prog[$];
    int          errors = 0;
    int          checks = 0;
    int          cycles = 0;
    exp_t        e;
    logic [63:0] obs;

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
    endfunction
    function automatic logic [31:0] ld(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
        return enc_i(imm, rs1, 3'b011, rd, 7'b0000011);
    endfunction
    function automatic logic [31:0] sd(input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [63:0] observe(input exp_t x);
        case (x.kind)
            0:       return dut.reg_file.registers[x.idx];
            1:       return dut.dmem.memory[x.idx];
            default: return 64'(cycles);
        endcase
    endfunction

    task automatic push(input int kind, input int idx, input logic [63:0] val);
        exp_t x;
        x.kind = kind;
        x.idx  = idx;
        x.val  = val;
        sb.push_back(x);
    endtask

    // Hold reset, fill imem with NOPs plus the program, and apply one reset edge.
    task automatic load_prog();
        reset = 1'b1;
        for (int i = 0; i < 256; i++) dut.imem.memory[i] = 32'h0000_0013;
        foreach (prog[i]) dut.imem.memory[i] = prog[i];
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_end();
        reset  = 1'b0;
        cycles = 0;
        while (end_program !== 1'b1 && cycles < 300) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checks++;
        if (end_program !== 1'b1) begin
            errors++;
            $display("FAIL end_program_timeout: got %b after %0d cycles, required 1", end_program, cycles);
        end
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        prog = {32'h00500093, 32'h00608313, 32'hFFFFFFFF};
        load_prog();
        checks++;
        if (end_program !== 1'b0) begin
            errors++;
            $display("FAIL reset_end_program: got %b required 0", end_program);
        end
        for (int r = 0; r < 32; r++) push(0, r, 64'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e); checks++;
            if (obs !== e.val) begin
                errors++;
                $display("FAIL reset kind=%0d idx=%0d: got %0d required %0d", e.kind, e.idx, obs, e.val);
            end
        end
    endtask

    task automatic test_forward();
        prog = {32'h00500093, 32'h00608313, 32'hFFFFFFFF};
        load_prog();
        for (int r = 0; r < 32; r++) push(0, r, (r == 1) ? 64'd5 : (r == 6) ? 64'd11 : 64'd0);
        for (int m = 0; m < 256; m++) push(1, m, 64'd0);
        push(2, 0, 64'd4);
        run_to_end();
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e); checks++;
            if (obs !== e.val) begin
                errors++;
                $display("FAIL forward kind=%0d idx=%0d: got %0d required %0d", e.kind, e.idx, obs, e.val);
            end
        end
    endtask

    task automatic test_alu();
        prog = {addi(1, 0, 7), addi(2, 0, 3), rtype(7'b0100000, 2, 1, 3'b000, 3),
                rtype(7'b0, 2, 1, 3'b111, 4), rtype(7'b0, 2, 1, 3'b110, 5), 32'hFFFFFFFF};
        load_prog();
        push(0, 1, 64'd7); push(0, 2, 64'd3); push(0, 3, 64'd4);
        push(0, 4, 64'd3); push(0, 5, 64'd7); push(2, 0, 64'd7);
        run_to_end();
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e); checks++;
            if (obs !== e.val) begin
                errors++;
                $display("FAIL alu kind=%0d idx=%0d: got %0d required %0d", e.kind, e.idx, obs, e.val);
            end
        end
    endtask

    task automatic test_load_use();
        prog = {addi(1, 0, 42), sd(1, 0, 12'd16), ld(2, 0, 12'd16), addi(3, 2, 1), 32'hFFFFFFFF};
        load_prog();
        push(1, 2, 64'd42); push(0, 1, 64'd42); push(0, 2, 64'd42); push(0, 3, 64'd43);
        push(2, 0, 64'd7);  // one stall cycle on top of the six-cycle baseline
        run_to_end();
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e); checks++;
            if (obs !== e.val) begin
                errors++;
                $display("FAIL load_use kind=%0d idx=%0d: got %0d required %0d", e.kind, e.idx, obs, e.val);
            end
        end
    endtask

    task automatic test_branch();
        for (int t = 0; t < 2; t++) begin
            prog = {addi(1, 0, 1), beq(1, (t == 0) ? 5'd1 : 5'd0, 13'd8), addi(2, 0, 9),
                    addi(3, 0, 5), 32'hFFFFFFFF};
            load_prog();
            push(0, 1, 64'd1);
            push(0, 2, (t == 0) ? 64'd0 : 64'd9);
            push(0, 3, 64'd5);
            push(2, 0, (t == 0) ? 64'd7 : 64'd6);
            run_to_end();
            while (sb.size() > 0) begin
                e = sb.pop_front(); obs = observe(e); checks++;
                if (obs !== e.val) begin
                    errors++;
                    $display("FAIL branch taken=%0d kind=%0d idx=%0d: got %0d required %0d",
                             (t == 0), e.kind, e.idx, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_x0();
        prog = {addi(0, 0, 5), rtype(7'b0, 0, 0, 3'b000, 1), 32'hFFFFFFFF};
        load_prog();
        push(0, 0, 64'd0); push(0, 1, 64'd0); push(2, 0, 64'd4);
        run_to_end();
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e); checks++;
            if (obs !== e.val) begin
                errors++;
                $display("FAIL x0 kind=%0d idx=%0d: got %0d required %0d", e.kind, e.idx, obs, e.val);
            end
        end
    endtask

    task automatic test_mid_reset();
        prog = {addi(1, 0, 7), addi(2, 0, 3), rtype(7'b0100000, 2, 1, 3'b000, 3),
                rtype(7'b0, 2, 1, 3'b111, 4), rtype(7'b0, 2, 1, 3'b110, 5), 32'hFFFFFFFF};
        load_prog();
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        push(0, 1, 64'd7);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e); checks++;
            if (obs !== e.val) begin
                errors++;
                $display("FAIL mid_reset_before idx=%0d: got %0d required %0d", e.idx, obs, e.val);
            end
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (end_program !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_end_program: got %b required 0", end_program);
        end
        for (int r = 0; r < 32; r++) push(0, r, 64'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e); checks++;
            if (obs !== e.val) begin
                errors++;
                $display("FAIL mid_reset_cleared idx=%0d: got %0d required %0d", e.idx, obs, e.val);
            end
        end
        push(0, 1, 64'd7); push(0, 2, 64'd3); push(0, 3, 64'd4);
        push(0, 4, 64'd3); push(0, 5, 64'd7); push(2, 0, 64'd7);
        run_to_end();
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e); checks++;
            if (obs !== e.val) begin
                errors++;
                $display("FAIL mid_reset_rerun kind=%0d idx=%0d: got %0d required %0d", e.kind, e.idx, obs, e.val);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_forward();
        test_alu();
        test_load_use();
        test_branch();
        test_x0();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/riscv_cpu_pipelined.md
Name: riscv_cpu_pipelined

Overview:
- Five-stage in-order RV64I-subset pipeline: IF, ID, EX, MEM, WB.
- Contains its own instruction memory, register file and data memory.
- Benches preload the instruction memory and inspect the register file and data memory hierarchically.
- Signals program completion on end_program when the halt sentinel 0xFFFFFFFF is decoded.

Parameters:
- IMEM_DEPTH, 256: instruction memory entries, 32-bit each.
- DMEM_DEPTH, 256: data memory entries, 64-bit each.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- end_program  output  1  sticky flag; high once the halt sentinel is decoded in ID.

Behaviour:
- Required sub-instances and arrays (fixed names for hierarchical access):
  - imem.memory[0:IMEM_DEPTH-1], 32-bit, word index = PC[..:2].
  - reg_file.registers[0:31], 64-bit.
  - dmem.memory[0:DMEM_DEPTH-1], 64-bit, index = address[..:3].
- Memory initialisation and reset:
  - imem is never written by the core and is not cleared by reset; contents loaded before reset deassertion must survive it.
  - dmem is zero-initialised at time 0 and not cleared by reset.
  - Reset clears PC to RESET_PC, all pipeline registers to bubbles (NOP, no writes), all 32 registers to 0, and end_program to 0.
- Supported instructions; anything else executes as a NOP:
  - add, sub, and, or (opcode 0110011).
  - addi (0010011).
  - ld (0000011, funct3 011).
  - sd (0100011, funct3 011).
  - beq (1100011).
  - Immediates are sign-extended to 64 bits; arithmetic wraps modulo 2^64.
- x0 always reads 0; writes to x0 are discarded.
- Register file writes in WB on the rising edge. Reads in ID see the same-cycle WB value (write-before-read bypass).
- Forwarding to EX operands:
  - EX/MEM result has priority over MEM/WB result.
  - Forward only when the destination rd != 0 and the producer writes a register.
- Load-use hazard: when the ID instruction reads the rd of an ld in EX:
  - stall PC and IF/ID for 1 cycle;
  - insert a bubble into ID/EX.
- Branches:
  - beq resolves in EX; taken target = PC + sign-extended B-immediate.
  - When taken, flush IF/ID and ID/EX to bubbles (2-cycle penalty) and redirect PC.
  - Not-taken beq has no penalty.
- Data memory:
  - sd writes on the rising edge in MEM.
  - ld reads combinationally in MEM; data is registered into MEM/WB.
  - Out-of-range addresses: loads return 0, stores are ignored.
- Halt:
  - When IF/ID holds 0xFFFFFFFF and it is not being flushed in that cycle, set end_program on the next edge and freeze the PC.
  - From then on, fetch injects only bubbles.
  - Older instructions still drain through MEM and WB; all architectural writes complete within 4 cycles after end_program rises.
- Fetch past IMEM_DEPTH returns NOP (0x00000013).
- A reset asserted mid-execution aborts all in-flight instructions (none of them write) and restarts from RESET_PC.

Test Plan:
- Preload imem 0x00500093, 0x00608313, 0xFFFFFFFF; reset for 1 edge; run until end_program plus 5 cycles -> x1=5, x6=11, all other registers 0, dmem all 0. This also checks EX/MEM forwarding.
- Program: addi x1,x0,7; addi x2,x0,3; sub x3,x1,x2; and x4,x1,x2; or x5,x1,x2; halt -> x3=4, x4=3, x5=7.
- Program: addi x1,x0,42; sd x1,16(x0); ld x2,16(x0); addi x3,x2,1; halt -> dmem.memory[2]=42, x2=42, x3=43; exactly one load-use stall cycle.
- Program: addi x1,x0,1; beq x1,x1,+8; addi x2,x0,9; addi x3,x0,5; halt -> x2=0 (flushed), x3=5. Also run with beq x1,x0 (not taken) -> x2=9.
- Program: addi x0,x0,5; add x1,x0,x0; halt -> x0=0, x1=0.
- Assert reset for 1 cycle mid-program, then release -> end_program=0 and all registers=0 immediately after reset; the program then re-executes to the same final state as an uninterrupted run.
